// File: rtl/vga_pkg.sv
// vga_pkg
//   Shared definitions for the VGA timing generator:
//   - default 640x480@60 mode constants (pixel counts per region)
//   - sync polarity encodings
//   - helpers deriving the total line / frame length from a mode
//   - the per-position decode result type
package vga_pkg;

    // Default mode: 640x480@60 (25.175 MHz pixel clock).
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    // Level at which a sync output is driven while its pulse is asserted.
    localparam logic SYNC_ACTIVE_LOW  = 1'b0;
    localparam logic SYNC_ACTIVE_HIGH = 1'b1;

    // Total pixels per line: active, front porch, sync, back porch.
    function automatic int h_total(input int active, input int fp,
                                   input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    // Total lines per frame, same region order as a line.
    function automatic int v_total(input int active, input int fp,
                                   input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    // Decoded attributes of one (h, v) position.
    typedef struct packed {
        logic active;
        logic hsync;
        logic vsync;
        logic vblank;
    } vga_decode_t;

endpackage

// File: rtl/vga_timing_gen_pos.sv
// vga_pos_counter
//   (h, v) raster position counter. h counts pixels in a line and wraps
//   explicitly at H_TOTAL-1; each wrap advances v, which wraps explicitly
//   at V_TOTAL-1. Advances only on clk edges where pix_en=1. Reset loads
//   the position (RST_H, RST_V) regardless of pix_en.
// Ports:
//   clk     in   pixel-domain clock
//   rst     in   synchronous active-high reset
//   pix_en  in   pixel tick
//   h       out  CW  current column
//   v       out  CW  current line
module vga_pos_counter #(
    parameter int CW      = 11,
    parameter int H_TOTAL = 800,
    parameter int V_TOTAL = 525,
    parameter int RST_H   = 0,
    parameter int RST_V   = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pix_en,
    output logic [CW-1:0] h,
    output logic [CW-1:0] v
);

    localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_INIT = CW'(RST_H);
    localparam logic [CW-1:0] V_INIT = CW'(RST_V);
    localparam logic [CW-1:0] ONE    = CW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            h <= H_INIT;
            v <= V_INIT;
        end else if (pix_en) begin
            if (h == H_LAST) begin
                h <= '0;
                if (v == V_LAST) begin
                    v <= '0;
                end else begin
                    v <= v + ONE;
                end
            end else begin
                h <= h + ONE;
            end
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Parametrised VGA raster timing generator. Produces registered sync,
//   active/blanking, pixel coordinates and line/frame strobes, plus a lead
//   coordinate set that runs LEAD pixel ticks ahead of the main outputs so
//   a pixel pipeline can prefetch.
// Ports:
//   clk          in   pixel-domain clock
//   rst          in   synchronous active-high reset
//   pix_en       in   pixel tick; timing advances only when high
//   hsync        out  horizontal sync at H_SYNC_POL
//   vsync        out  vertical sync at V_SYNC_POL (whole-line decode)
//   active       out  current pixel is visible
//   vblank       out  current line is in vertical blanking
//   x, y         out  CW  current pixel position
//   line_start   out  one-clk strobe when x=0 is presented
//   frame_start  out  one-clk strobe when (0,0) is presented
//   lead_active  out  active, LEAD ticks ahead
//   lead_x/y     out  CW  position, LEAD ticks ahead
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE   = DEF_H_ACTIVE,
    parameter int   H_FP       = DEF_H_FP,
    parameter int   H_SYNC     = DEF_H_SYNC,
    parameter int   H_BP       = DEF_H_BP,
    parameter int   V_ACTIVE   = DEF_V_ACTIVE,
    parameter int   V_FP       = DEF_V_FP,
    parameter int   V_SYNC     = DEF_V_SYNC,
    parameter int   V_BP       = DEF_V_BP,
    parameter logic H_SYNC_POL = SYNC_ACTIVE_LOW,
    parameter logic V_SYNC_POL = SYNC_ACTIVE_LOW,
    parameter int   CW         = 11,
    parameter int   LEAD       = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pix_en,
    output logic          hsync,
    output logic          vsync,
    output logic          active,
    output logic          vblank,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          line_start,
    output logic          frame_start,
    output logic          lead_active,
    output logic [CW-1:0] lead_x,
    output logic [CW-1:0] lead_y
);

    localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    // Lead counter starts LEAD positions ahead, folded across line and
    // frame boundaries so any LEAD in range lands on a legal position.
    localparam int LEAD_H = LEAD % H_TOTAL;
    localparam int LEAD_V = (LEAD / H_TOTAL) % V_TOTAL;

    // Region boundaries as CW-bit unsigned values; 2^CW > totals, so the
    // exclusive end of each sync region is still representable.
    localparam logic [CW-1:0] H_ACT_END  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] HS_START   = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END     = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] V_ACT_END  = CW'(V_ACTIVE);
    localparam logic [CW-1:0] VS_START   = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END     = CW'(V_ACTIVE + V_FP + V_SYNC);

    logic [CW-1:0] h_main, v_main;
    logic [CW-1:0] h_lead, v_lead;
    vga_decode_t   dec_main;
    logic          lead_vis;

    vga_pos_counter #(
        .CW      (CW),
        .H_TOTAL (H_TOTAL),
        .V_TOTAL (V_TOTAL),
        .RST_H   (0),
        .RST_V   (0)
    ) u_main_pos (
        .clk    (clk),
        .rst    (rst),
        .pix_en (pix_en),
        .h      (h_main),
        .v      (v_main)
    );

    vga_pos_counter #(
        .CW      (CW),
        .H_TOTAL (H_TOTAL),
        .V_TOTAL (V_TOTAL),
        .RST_H   (LEAD_H),
        .RST_V   (LEAD_V)
    ) u_lead_pos (
        .clk    (clk),
        .rst    (rst),
        .pix_en (pix_en),
        .h      (h_lead),
        .v      (v_lead)
    );

    // Visible-region test, shared by the main decode and the lead path.
    function automatic logic is_active(input logic [CW-1:0] h,
                                       input logic [CW-1:0] v);
        return (h < H_ACT_END) && (v < V_ACT_END);
    endfunction

    // Full decode of one raster position.
    function automatic vga_decode_t decode(input logic [CW-1:0] h,
                                           input logic [CW-1:0] v);
        vga_decode_t d;
        logic        hs_on;
        logic        vs_on;
        hs_on    = (h >= HS_START) && (h < HS_END);
        vs_on    = (v >= VS_START) && (v < VS_END);
        d.active = is_active(h, v);
        d.hsync  = (H_SYNC_POL == SYNC_ACTIVE_HIGH) ? hs_on : !hs_on;
        d.vsync  = (V_SYNC_POL == SYNC_ACTIVE_HIGH) ? vs_on : !vs_on;
        d.vblank = (v >= V_ACT_END);
        return d;
    endfunction

    always_comb begin
        dec_main = decode(h_main, v_main);
        lead_vis = is_active(h_lead, v_lead);
    end

    // Outputs capture the decode of the position being left on each tick,
    // giving one tick of latency. Strobes self-clear on every non-tick clk.
    always_ff @(posedge clk) begin
        if (rst) begin
            hsync       <= !H_SYNC_POL;
            vsync       <= !V_SYNC_POL;
            active      <= 1'b0;
            vblank      <= 1'b0;
            x           <= '0;
            y           <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            lead_active <= 1'b0;
            lead_x      <= '0;
            lead_y      <= '0;
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            if (pix_en) begin
                hsync       <= dec_main.hsync;
                vsync       <= dec_main.vsync;
                active      <= dec_main.active;
                vblank      <= dec_main.vblank;
                x           <= h_main;
                y           <= v_main;
                line_start  <= (h_main == '0);
                frame_start <= (h_main == '0) && (v_main == '0);
                lead_active <= lead_vis;
                lead_x      <= h_lead;
                lead_y      <= v_lead;
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen
//   Bench for vga_timing_gen. Two instances share one clock:
//   dut_a: default 640x480 mode, LEAD=3, active-low syncs.
//   dut_b: 15x7 mode (H 8/2/3/2, V 4/1/1/1), active-high syncs, CW=4, LEAD=3.
module tb_vga_timing_gen;
    localparam int CW_A   = 11;
    localparam int CW_B   = 4;
    localparam int LEAD_N = 3;
    localparam int QW_A   = 2 * CW_A + 1;
    localparam int QW_B   = 2 * CW_B + 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, pix_en_a, rst_b, pix_en_b;

    logic            hsync_a, vsync_a, active_a, vblank_a;
    logic            line_start_a, frame_start_a, lead_active_a;
    logic [CW_A-1:0] x_a, y_a, lead_x_a, lead_y_a;

    logic            hsync_b, vsync_b, active_b, vblank_b;
    logic            line_start_b, frame_start_b, lead_active_b;
    logic [CW_B-1:0] x_b, y_b, lead_x_b, lead_y_b;

    vga_timing_gen #(.LEAD(LEAD_N)) dut_a (
        .clk         (clk),
        .rst         (rst_a),
        .pix_en      (pix_en_a),
        .hsync       (hsync_a),
        .vsync       (vsync_a),
        .active      (active_a),
        .vblank      (vblank_a),
        .x           (x_a),
        .y           (y_a),
        .line_start  (line_start_a),
        .frame_start (frame_start_a),
        .lead_active (lead_active_a),
        .lead_x      (lead_x_a),
        .lead_y      (lead_y_a)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .CW(CW_B), .LEAD(LEAD_N)
    ) dut_b (
        .clk         (clk),
        .rst         (rst_b),
        .pix_en      (pix_en_b),
        .hsync       (hsync_b),
        .vsync       (vsync_b),
        .active      (active_b),
        .vblank      (vblank_b),
        .x           (x_b),
        .y           (y_b),
        .line_start  (line_start_b),
        .frame_start (frame_start_b),
        .lead_active (lead_active_b),
        .lead_x      (lead_x_b),
        .lead_y      (lead_y_b)
    );

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    // Lead outputs seen now are the main outputs expected LEAD ticks later.
    logic [QW_A-1:0] exp_q_a[$];
    logic [QW_B-1:0] exp_q_b[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step_a(input logic en);
        pix_en_a = en;
        @(posedge clk);
        #1;
    endtask

    task automatic step_b(input logic en);
        pix_en_b = en;
        @(posedge clk);
        #1;
    endtask

    task automatic adv(inout int h, inout int v, input int ht, input int vt);
        h++;
        if (h == ht) begin
            h = 0;
            v++;
            if (v == vt) v = 0;
        end
    endtask

    task automatic reset_a();
        rst_a    = 1'b1;
        pix_en_a = 1'b0;
        @(posedge clk);
        #1;
        rst_a = 1'b0;
        exp_q_a.delete();
    endtask

    // ---------------- expected-value checks ----------------
    task automatic chk_reset_a(input string tag);
        check({tag, "_hsync"},  32'(hsync_a), 32'd1);
        check({tag, "_vsync"},  32'(vsync_a), 32'd1);
        check({tag, "_active"}, 32'(active_a), 32'd0);
        check({tag, "_vblank"}, 32'(vblank_a), 32'd0);
        check({tag, "_x"},      32'(x_a), 32'd0);
        check({tag, "_y"},      32'(y_a), 32'd0);
        check({tag, "_ls"},     32'(line_start_a), 32'd0);
        check({tag, "_fs"},     32'(frame_start_a), 32'd0);
        check({tag, "_lact"},   32'(lead_active_a), 32'd0);
        check({tag, "_lx"},     32'(lead_x_a), 32'd0);
        check({tag, "_ly"},     32'(lead_y_a), 32'd0);
    endtask

    // Main outputs of dut_a for presented position (h, v); fresh=0 means
    // a non-tick clk, where strobes must be low.
    task automatic chk_a(input int h, input int v, input bit fresh);
        check("a_x",      32'(x_a), 32'(h));
        check("a_y",      32'(y_a), 32'(v));
        check("a_active", 32'(active_a), 32'(h < 640 && v < 480));
        check("a_hsync",  32'(hsync_a), 32'(!(h >= 656 && h < 752)));
        check("a_vsync",  32'(vsync_a), 32'(!(v >= 490 && v < 492)));
        check("a_vblank", 32'(vblank_a), 32'(v >= 480));
        check("a_ls",     32'(line_start_a), 32'(fresh && h == 0));
        check("a_fs",     32'(frame_start_a), 32'(fresh && h == 0 && v == 0));
    endtask

    task automatic chk_b(input int h, input int v);
        check("b_x",      32'(x_b), 32'(h));
        check("b_y",      32'(y_b), 32'(v));
        check("b_active", 32'(active_b), 32'(h < 8 && v < 4));
        check("b_hsync",  32'(hsync_b), 32'(h >= 10 && h <= 12));
        check("b_vsync",  32'(vsync_b), 32'(v == 5));
        check("b_vblank", 32'(vblank_b), 32'(v >= 4));
        check("b_ls",     32'(line_start_b), 32'(h == 0));
        check("b_fs",     32'(frame_start_b), 32'(h == 0 && v == 0));
    endtask

    task automatic lead_a();
        exp_q_a.push_back({lead_active_a, lead_y_a, lead_x_a});
        if (exp_q_a.size() > LEAD_N)
            check("a_lead", 32'(exp_q_a.pop_front()), 32'({active_a, y_a, x_a}));
    endtask

    task automatic lead_b();
        exp_q_b.push_back({lead_active_b, lead_y_b, lead_x_b});
        if (exp_q_b.size() > LEAD_N)
            check("b_lead", 32'(exp_q_b.pop_front()), 32'({active_b, y_b, x_b}));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int h, v, ph, pv;
        int hs_low, first_low, ls_cnt;
        int hs_hi, first_hi, vs_hi, fs_cnt, fs_prev, fs_gap;

        rst_a = 1'b1; pix_en_a = 1'b0;
        rst_b = 1'b1; pix_en_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_a("rst_a");
        check("rst_b_hsync", 32'(hsync_b), 32'd0);
        check("rst_b_vsync", 32'(vsync_b), 32'd0);
        check("rst_b_active", 32'(active_b), 32'd0);
        check("rst_b_fs", 32'(frame_start_b), 32'd0);
        rst_a = 1'b0;
        rst_b = 1'b0;

        // Phase 1: continuous ticks over 12 lines of the default mode.
        h = 0; v = 0;
        hs_low = 0; first_low = -1; ls_cnt = 0;
        for (int t = 0; t < 9600; t++) begin
            step_a(1'b1);
            chk_a(h, v, 1'b1);
            lead_a();
            if (h == 798 && v == 10) begin
                check("a_lead_wrap_x", 32'(lead_x_a), 32'd1);
                check("a_lead_wrap_y", 32'(lead_y_a), 32'd11);
            end
            if (y_a == 0 && hsync_a == 1'b0) begin
                hs_low++;
                if (first_low < 0) first_low = int'(x_a);
            end
            if (line_start_a) ls_cnt++;
            adv(h, v, 800, 525);
        end
        check("a_hs_width", 32'(hs_low), 32'd96);
        check("a_hs_first", 32'(first_low), 32'd656);
        check("a_line_cnt", 32'(ls_cnt), 32'd12);

        // Phase 2: pix_en alternating 1/0 -> same sequence at half rate.
        reset_a();
        chk_reset_a("rst2_a");
        h = 0; v = 0; ph = 0; pv = 0;
        for (int t = 0; t < 3200; t++) begin
            if (t % 2 == 0) begin
                step_a(1'b1);
                chk_a(h, v, 1'b1);
                lead_a();
                ph = h; pv = v;
                adv(h, v, 800, 525);
            end else begin
                step_a(1'b0);
                chk_a(ph, pv, 1'b0);
            end
        end

        // Phase 3: reset mid-frame, during hsync, together with pix_en.
        reset_a();
        for (int t = 0; t < 2 * 800 + 701; t++) step_a(1'b1);
        check("a_pre_x", 32'(x_a), 32'd700);
        check("a_pre_y", 32'(y_a), 32'd2);
        check("a_pre_hs", 32'(hsync_a), 32'd0);
        rst_a = 1'b1;
        step_a(1'b1);
        rst_a = 1'b0;
        chk_reset_a("midrst_a");
        step_a(1'b0);
        chk_reset_a("midrst_hold_a");
        step_a(1'b1);
        chk_a(0, 0, 1'b1);
        check("a_post_lx", 32'(lead_x_a), 32'd3);
        check("a_post_ly", 32'(lead_y_a), 32'd0);
        check("a_post_lact", 32'(lead_active_a), 32'd1);
        step_a(1'b0);
        chk_a(0, 0, 1'b0);

        // Phase 4: small mode, active-high syncs, two full frames.
        h = 0; v = 0;
        hs_hi = 0; first_hi = -1; vs_hi = 0; ls_cnt = 0;
        fs_cnt = 0; fs_prev = -1; fs_gap = 0;
        for (int t = 0; t < 210; t++) begin
            step_b(1'b1);
            chk_b(h, v);
            lead_b();
            if (h == 14 && v == 6) begin
                check("b_lead_wrap_x", 32'(lead_x_b), 32'd2);
                check("b_lead_wrap_y", 32'(lead_y_b), 32'd0);
            end
            if (hsync_b) begin
                hs_hi++;
                if (first_hi < 0) first_hi = int'(x_b);
            end
            if (vsync_b) vs_hi++;
            if (line_start_b) ls_cnt++;
            if (frame_start_b) begin
                fs_cnt++;
                if (fs_prev >= 0) fs_gap = t - fs_prev;
                fs_prev = t;
            end
            adv(h, v, 15, 7);
        end
        check("b_hs_ticks", 32'(hs_hi), 32'd42);
        check("b_hs_first", 32'(first_hi), 32'd10);
        check("b_vs_ticks", 32'(vs_hi), 32'd30);
        check("b_line_cnt", 32'(ls_cnt), 32'd14);
        check("b_frame_cnt", 32'(fs_cnt), 32'd2);
        check("b_frame_period", 32'(fs_gap), 32'd105);

        // ---------------- report ----------------
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
